y86_stat_ctrl: RTL and testbench

Run/halt controller for the sequential Y86-64 core. It consumes the per-instruction status from fetch and memory (`icode`, `instruct_err`, `mem_err`) and classifies it into the architectural Stat code. It gates every state-update enable (PC, register file, data-memory write), so halting and faulting instructions never commit. It also provides start/clear control and a single-step mode for bring-up.

---
 rtl/y86_pkg.sv | 34 +++
 rtl/y86_stat_classify.sv | 29 ++
 rtl/y86_stat_ctrl.sv | 148 ++++++++++++++
 tb/tb_y86_stat_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86-64 status codes, instruction codes and controller state
// Purpose: common types and constants used by the run/halt controller and
//          the status classifier.
// Ports:   none (package).
package y86_pkg;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/y86_stat_classify.sv
// rtl/y86_stat_classify.sv - combinational priority classifier for instruction status
// Purpose: maps (mem_err, instruct_err, icode) to the architectural Stat code.
//          Priority: ADR > INS > HLT > AOK.
// Ports:
//   mem_err_i       - instruction/data memory address error
//   instruct_err_i  - invalid instruction
//   icode_i [3:0]   - instruction code
//   stat_o  [2:0]   - resulting Stat code
module y86_stat_classify
  import y86_pkg::*;
(
  input  logic       mem_err_i,
  input  logic       instruct_err_i,
  input  logic [3:0] icode_i,
  output logic [2:0] stat_o
);

  always_comb begin
    stat_o = STAT_AOK;
    if (mem_err_i) begin
      stat_o = STAT_ADR;
    end else if (instruct_err_i) begin
      stat_o = STAT_INS;
    end else if (icode_i == IHALT) begin
      stat_o = STAT_HLT;
    end
  end

endmodule

// File: rtl/y86_stat_ctrl.sv
// rtl/y86_stat_ctrl.sv - run/halt controller and commit gating for the sequential Y86-64 core
// Purpose: classifies each executed instruction into Stat, gates PC/register/
//          data-memory updates so halting or faulting instructions never commit,
//          and provides start/clear and single-step control.
// Optional feature: Y86_RETIRE_CNT_EN adds the retired-instruction counter
//          and its retired_cnt_o port.
// Ports:
//   clk_i, rst_ni            - clock, asynchronous active-low reset
//   start_i, clear_i         - IDLE->RUN, HALT/FAULT->IDLE
//   step_mode_i, step_i      - single-step control
//   icode_i, instruct_err_i, mem_err_i - per-instruction status
//   pc_we_o, reg_we_o, dmem_we_en_o    - commit gates (zero latency)
//   stat_o                   - registered Stat code
//   running_o, done_o        - state flags
//   retired_cnt_o            - retired instruction count (macro only)
module y86_stat_ctrl
  import y86_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic             step_mode_i,
  input  logic             step_i,
  input  logic [3:0]       icode_i,
  input  logic             instruct_err_i,
  input  logic             mem_err_i,
  output logic             pc_we_o,
  output logic             reg_we_o,
  output logic             dmem_we_en_o,
  output logic [2:0]       stat_o,
  output logic             running_o,
`ifdef Y86_RETIRE_CNT_EN
  output logic             done_o,
  output logic [CNT_W-1:0] retired_cnt_o
`else
  output logic             done_o
`endif
);

  ctrl_state_e state_q, state_d;
  logic [2:0]  stat_q, stat_d;
  logic [2:0]  cls;
  logic        exec;
  logic        commit;
  logic        idle_entry;

  y86_stat_classify u_classify (
    .mem_err_i      (mem_err_i),
    .instruct_err_i (instruct_err_i),
    .icode_i        (icode_i),
    .stat_o         (cls)
  );

  // An instruction is executed only in RUN, and in step mode only with a step pulse.
  assign exec       = (state_q == ST_RUN) && (!step_mode_i || step_i);
  assign commit     = exec && (cls == STAT_AOK);
  assign idle_entry = (state_q != ST_IDLE) && (state_d == ST_IDLE);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (exec) begin
          if (cls == STAT_HLT) begin
            state_d = ST_HALT;
          end else if (cls != STAT_AOK) begin
            state_d = ST_FAULT;
          end
        end
      end
      ST_HALT, ST_FAULT: begin
        // clear wins over a simultaneous start; a fresh start is needed from IDLE.
        if (clear_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    pc_we_o      = commit;
    reg_we_o     = commit;
    dmem_we_en_o = commit;
    running_o    = (state_q == ST_RUN);
    done_o       = (state_q == ST_HALT) || (state_q == ST_FAULT);
  end

  // Stat holds the class of the last executed instruction; frozen once terminal.
  always_comb begin
    stat_d = stat_q;
    if (exec) begin
      stat_d = cls;
    end else if (idle_entry) begin
      stat_d = STAT_AOK;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_q <= STAT_AOK;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_o = stat_q;

`ifdef Y86_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Wraps naturally at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (idle_entry) begin
      cnt_d = '0;
    end else if (commit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign retired_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_y86_stat_ctrl.sv
// tb/tb_y86_stat_ctrl.sv - self-checking bench for y86_stat_ctrl
module tb_y86_stat_ctrl;

  localparam int CW = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic       step_mode = 1'b0;
  logic       step = 1'b0;
  logic [3:0] icode = 4'd1;
  logic       ierr = 1'b0;
  logic       merr = 1'b0;
  logic       pc_we, reg_we, dmem_we_en, running, done;
  logic [2:0] stat;
`ifdef Y86_RETIRE_CNT_EN
  logic [CW-1:0] retired_cnt;
`endif

  y86_stat_ctrl #(.CNT_W(CW)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .clear_i        (clear),
    .step_mode_i    (step_mode),
    .step_i         (step),
    .icode_i        (icode),
    .instruct_err_i (ierr),
    .mem_err_i      (merr),
    .pc_we_o        (pc_we),
    .reg_we_o       (reg_we),
    .dmem_we_en_o   (dmem_we_en),
    .stat_o         (stat),
    .running_o      (running),
`ifdef Y86_RETIRE_CNT_EN
    .done_o         (done),
    .retired_cnt_o  (retired_cnt)
`else
    .done_o         (done)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: 0 idle, 1 run, 2 halted, 3 faulted
  int m_state = 0;
  int m_stat  = 1;
  int m_cnt   = 0;
  int pc_we_seen;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_class(input bit me, input bit ie, input int ic);
    if (me) return 3;
    if (ie) return 4;
    if (ic == 0) return 2;
    return 1;
  endfunction

  function automatic bit m_exec();
    return (m_state == 1) && (!step_mode || step);
  endfunction

  task automatic compare_cycle();
    bit g;
    g = m_exec() && (exp_class(merr, ierr, int'(icode)) == 1);
    check("pc_we", int'(pc_we), int'(g));
    check("reg_we", int'(reg_we), int'(g));
    check("dmem_we_en", int'(dmem_we_en), int'(g));
    check("stat", int'(stat), m_stat);
    check("running", int'(running), int'(m_state == 1));
    check("done", int'(done), int'(m_state >= 2));
`ifdef Y86_RETIRE_CNT_EN
    check("retired_cnt", int'(retired_cnt), m_cnt);
`endif
    if (pc_we === 1'b1) pc_we_seen++;
  endtask

  task automatic model_step();
    int c;
    c = exp_class(merr, ierr, int'(icode));
    case (m_state)
      0: if (start) m_state = 1;
      1: if (m_exec()) begin
           m_stat = c;
           if (c == 1) m_cnt = (m_cnt + 1) % (1 << CW);
           else if (c == 2) m_state = 2;
           else m_state = 3;
         end
      default: if (clear) begin
           m_state = 0;
           m_stat  = 1;
           m_cnt   = 0;
         end
    endcase
  endtask

  // One clock: compare mid-cycle, advance model at the edge, return just after it.
  task automatic tick();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_in(input bit s, input bit c, input bit sm, input bit st,
                        input int ic, input bit ie, input bit me);
    start = s; clear = c; step_mode = sm; step = st;
    icode = 4'(ic); ierr = ie; merr = me;
  endtask

  // Asynchronous reset pulse in the middle of a cycle; called just after an edge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    m_state = 0; m_stat = 1; m_cnt = 0;
    #1;
    check("rst_pc_we", int'(pc_we), 0);
    check("rst_reg_we", int'(reg_we), 0);
    check("rst_dmem_we", int'(dmem_we_en), 0);
    check("rst_stat", int'(stat), 1);
    check("rst_running", int'(running), 0);
    check("rst_done", int'(done), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1;
    check("reset_stat", int'(stat), 1);
    check("reset_running", int'(running), 0);
    check("reset_done", int'(done), 0);
    check("reset_pc_we", int'(pc_we), 0);
    rst_n = 1'b1;

    // Start then three AOK instructions
    set_in(1, 0, 0, 0, 6, 0, 0); tick();
    check("start_running", int'(running), 1);
    pc_we_seen = 0;
    set_in(0, 0, 0, 0, 6, 0, 0);
    repeat (3) tick();
    check("lit_three_commits", pc_we_seen, 3);
    check("lit_stat_aok", int'(stat), 1);
`ifdef Y86_RETIRE_CNT_EN
    check("lit_cnt3", int'(retired_cnt), 3);
`endif

    // Halt
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1 check("lit_halt_gate", int'(pc_we), 0);
    tick();
    check("lit_stat_hlt", int'(stat), 2);
    check("lit_done_hlt", int'(done), 1);
    check("lit_running_hlt", int'(running), 0);
    set_in(0, 0, 0, 0, 6, 0, 0); tick();
    check("lit_hlt_frozen", int'(stat), 2);
    set_in(0, 1, 0, 0, 6, 0, 0); tick();
    check("lit_clear_stat", int'(stat), 1);
    check("lit_clear_done", int'(done), 0);

    // ADR beats INS and HLT
    set_in(1, 0, 0, 0, 6, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 1, 1);
    #1 check("lit_adr_gate", int'(pc_we), 0);
    tick();
    check("lit_stat_adr", int'(stat), 3);
    check("lit_done_adr", int'(done), 1);
    set_in(0, 1, 0, 0, 6, 0, 0); tick();

    // Single step: 2 pulses in 5 cycles
    set_in(1, 0, 1, 0, 6, 0, 0); tick();
    pc_we_seen = 0;
    for (int i = 0; i < 5; i++) begin
      set_in(0, 0, 1, (i == 1 || i == 3), 6, 0, 0);
      tick();
    end
    check("lit_step_commits", pc_we_seen, 2);
`ifdef Y86_RETIRE_CNT_EN
    check("lit_step_cnt", int'(retired_cnt), 2);
`endif

    // Reset mid-run, then no commits without a fresh start
    set_in(0, 0, 0, 0, 6, 0, 0); tick();
    async_reset();
    pc_we_seen = 0;
    repeat (3) tick();
    check("lit_no_commit_after_reset", pc_we_seen, 0);

    // start+clear in IDLE -> RUN
    set_in(1, 1, 0, 0, 6, 0, 0); tick();
    check("lit_start_clear_idle", int'(running), 1);
    set_in(0, 0, 0, 0, 0, 0, 0); tick();
    // clear+start in HALT -> IDLE only
    set_in(1, 1, 0, 0, 6, 0, 0); tick();
    check("lit_clear_start_halt_run", int'(running), 0);
    check("lit_clear_start_halt_done", int'(done), 0);
    set_in(0, 0, 0, 0, 6, 0, 0); tick();
    check("lit_stays_idle", int'(running), 0);

`ifdef Y86_RETIRE_CNT_EN
    // Counter wrap at CW bits
    set_in(1, 0, 0, 0, 6, 0, 0); tick();
    set_in(0, 0, 0, 0, 6, 0, 0);
    repeat (17) tick();
    check("lit_cnt_wrap", int'(retired_cnt), 1);
`endif

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        async_reset();
      end
      set_in($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
             int'($urandom_range(0, 15)),
             $urandom_range(0, 24) == 0, $urandom_range(0, 24) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
